// File: rtl/acc_datapath_pkg.sv
// ----------------------------------------------------------------------------
// acc_datapath_pkg
//
// Purpose:
//   Shared definitions for the accumulator datapath: the 4-bit operation
//   encodings and the write-back FSM state type.
//
// Build option:
//   ACC_DATAPATH_DAA_EN - when defined, the op code shared with NOP
//                         performs the decimal adjust (DAA) instead.
//
// Ports:
//   (package - no ports)
// ----------------------------------------------------------------------------
package acc_datapath_pkg;

    // The op_code field is 4 bits wide. That gives 16 codes for 16 real
    // operations plus DAA. DAA therefore shares the NOP code. In a build
    // without the decimal adjust, code 0 is a plain NOP. In a build with
    // it, code 0 is DAA, and an idle cycle is requested by keeping
    // op_valid low.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_DAA = 4'h0;
    localparam logic [3:0] OP_LDM = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_CLB = 4'h4;
    localparam logic [3:0] OP_CLC = 4'h5;
    localparam logic [3:0] OP_STC = 4'h6;
    localparam logic [3:0] OP_CMC = 4'h7;
    localparam logic [3:0] OP_ADD = 4'h8;
    localparam logic [3:0] OP_SUB = 4'h9;
    localparam logic [3:0] OP_IAC = 4'hA;
    localparam logic [3:0] OP_DAC = 4'hB;
    localparam logic [3:0] OP_INC = 4'hC;
    localparam logic [3:0] OP_RAL = 4'hD;
    localparam logic [3:0] OP_RAR = 4'hE;
    localparam logic [3:0] OP_XCH = 4'hF;

    // The only multi-cycle operation is XCH. It needs one extra state to
    // write the old accumulator value back into the register file.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_XCH_WB = 1'b1
    } state_e;

endpackage

// File: rtl/acc_datapath_alu.sv
// ----------------------------------------------------------------------------
// acc_datapath_alu
//
// Purpose:
//   Purely combinational arithmetic and rotate unit for the accumulator
//   datapath. It covers ADD, SUB, IAC, DAC, RAL, RAR and, optionally, DAA.
//   For any other op code, the accumulator and carry pass through unchanged.
//
// Build option:
//   ACC_DATAPATH_DAA_EN - builds the decimal-adjust path for OP_DAA.
//
// Ports:
//   acc_i      in  WIDTH  current accumulator
//   operand_i  in  WIDTH  register-file operand (reg[op_reg])
//   carry_i    in  1      current carry flag
//   op_i       in  4      operation code
//   result_o   out WIDTH  new accumulator value
//   carry_o    out 1      new carry value
// ----------------------------------------------------------------------------
module acc_datapath_alu
    import acc_datapath_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic             carry_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum;
`ifdef ACC_DATAPATH_DAA_EN
    logic [4:0]     nibble;
`endif

    // The add-type ops share one WIDTH+1 bit sum. Its top bit becomes the
    // carry. For SUB, the carry acts as a "no borrow" flag in both
    // directions: a set carry brings in the +1 that completes the two's
    // complement of the operand, and a cleared carry-out means a borrow
    // happened. Rotates move the carry in as an extra bit on the opposite
    // end.
    always_comb begin
        result_o = acc_i;
        carry_o  = carry_i;
        sum      = '0;
`ifdef ACC_DATAPATH_DAA_EN
        nibble   = '0;
`endif
        case (op_i)
            OP_ADD: begin
                sum = {1'b0, acc_i} + {1'b0, operand_i} + {{WIDTH{1'b0}}, carry_i};
                {carry_o, result_o} = sum;
            end
            OP_SUB: begin
                sum = {1'b0, acc_i} + {1'b0, ~operand_i} + {{WIDTH{1'b0}}, carry_i};
                {carry_o, result_o} = sum;
            end
            OP_IAC: begin
                sum = {1'b0, acc_i} + {{WIDTH{1'b0}}, 1'b1};
                {carry_o, result_o} = sum;
            end
            OP_DAC: begin
                sum = {1'b0, acc_i} + {1'b0, {WIDTH{1'b1}}};
                {carry_o, result_o} = sum;
            end
            OP_RAL: begin
                carry_o  = acc_i[WIDTH-1];
                result_o = {acc_i[WIDTH-2:0], carry_i};
            end
            OP_RAR: begin
                carry_o  = acc_i[0];
                result_o = {carry_i, acc_i[WIDTH-1:1]};
            end
`ifdef ACC_DATAPATH_DAA_EN
            OP_DAA: begin
                if ((acc_i[3:0] > 4'd9) || carry_i) begin
                    nibble        = {1'b0, acc_i[3:0]} + 5'd6;
                    result_o[3:0] = nibble[3:0];
                    if (nibble[4]) begin
                        carry_o = 1'b1;
                    end
                end
            end
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/acc_datapath.sv
// ----------------------------------------------------------------------------
// acc_datapath
//
// Purpose:
//   A small accumulator machine with:
//     - a WIDTH-bit accumulator and a carry flag
//     - an NREGS-deep register file
//     - a two-state FSM that runs the two-cycle XCH exchange
//   Operations arrive on a valid/ready handshake. Every operation except
//   XCH completes on the edge that accepts it.
//
// Build option:
//   ACC_DATAPATH_DAA_EN - enables the DAA decimal adjust. It shares the NOP
//                         code, so without this define that code is a NOP.
//
// Ports:
//   clock        in  1      sole clock, rising edge
//   reset        in  1      asynchronous, active-low reset
//   op_valid     in  1      operation request
//   op_ready     out 1      operation can be accepted this cycle
//   op_code      in  4      operation select (see acc_datapath_pkg)
//   op_reg       in  AW     register index operand
//   op_imm       in  WIDTH  immediate operand (LDM)
//   rd_addr      in  AW     debug read address
//   rd_data      out WIDTH  registers[rd_addr], combinational
//   accumulator  out WIDTH  accumulator register
//   carry        out 1      carry register
// ----------------------------------------------------------------------------
module acc_datapath
    import acc_datapath_pkg::*;
#(
    parameter int  WIDTH = 4,
    parameter int  NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [AW-1:0]    op_reg,
    input  logic [WIDTH-1:0] op_imm,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] accumulator,
    output logic             carry
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [AW-1:0]    xch_reg_q, xch_reg_d;
    logic [WIDTH-1:0] xch_acc_q, xch_acc_d;
    logic [WIDTH-1:0] regs_q [NREGS];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    logic             accept;
    logic [WIDTH-1:0] reg_operand;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    // Ready is held low while reset is asserted, so no request can slip in
    // on the edge that releases reset.
    assign op_ready    = (state_q == ST_IDLE) && reset;
    assign accept      = op_valid && op_ready;
    assign reg_operand = regs_q[op_reg];
    assign rd_data     = regs_q[rd_addr];
    assign accumulator = acc_q;
    assign carry       = carry_q;

    acc_datapath_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .acc_i    (acc_q),
        .operand_i(reg_operand),
        .carry_i  (carry_q),
        .op_i     (op_code),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    // Next-state decode. Each operation has at most one register-file
    // write. In XCH_WB, nothing new is accepted, so the write-back is the
    // only writer in that cycle. XCH remembers the target index and the old
    // accumulator, so the write-back does not depend on op_reg still being
    // held.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        xch_reg_d = xch_reg_q;
        xch_acc_d = xch_acc_q;
        wr_en     = 1'b0;
        wr_addr   = op_reg;
        wr_data   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_LDM: acc_d = op_imm;
                        OP_LD:  acc_d = reg_operand;
                        OP_ST: begin
                            wr_en   = 1'b1;
                            wr_data = acc_q;
                        end
                        OP_CLB: begin
                            acc_d   = '0;
                            carry_d = 1'b0;
                        end
                        OP_CLC: carry_d = 1'b0;
                        OP_STC: carry_d = 1'b1;
                        OP_CMC: carry_d = ~carry_q;
                        OP_ADD, OP_SUB, OP_IAC, OP_DAC, OP_RAL, OP_RAR: begin
                            acc_d   = alu_result;
                            carry_d = alu_carry;
                        end
`ifdef ACC_DATAPATH_DAA_EN
                        OP_DAA: begin
                            acc_d   = alu_result;
                            carry_d = alu_carry;
                        end
`endif
                        OP_INC: begin
                            wr_en   = 1'b1;
                            wr_data = reg_operand + {{(WIDTH-1){1'b0}}, 1'b1};
                        end
                        OP_XCH: begin
                            xch_reg_d = op_reg;
                            xch_acc_d = acc_q;
                            acc_d     = reg_operand;
                            state_d   = ST_XCH_WB;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_XCH_WB: begin
                wr_en   = 1'b1;
                wr_addr = xch_reg_q;
                wr_data = xch_acc_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulator, carry, holding registers and FSM state. Reset clears
    // the FSM back to IDLE, which drops any pending XCH write-back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            xch_reg_q <= '0;
            xch_acc_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            xch_reg_q <= xch_reg_d;
            xch_acc_q <= xch_acc_d;
        end
    end

    // Register file with one write port and asynchronous clear of every
    // entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_acc_datapath.sv
// ----------------------------------------------------------------------------
// tb_acc_datapath
//
// Purpose:
//   Directed, self-checking bench for acc_datapath with WIDTH=4 and
//   NREGS=16. Every expected value is worked out by hand from the operation
//   semantics.
//
// Build option:
//   ACC_DATAPATH_DAA_EN - selects the DAA expectations.
// ----------------------------------------------------------------------------
module tb_acc_datapath;
    import acc_datapath_pkg::*;

    localparam int WIDTH = 4;
    localparam int NREGS = 16;
    localparam int AW    = 4;

    logic             clock;
    logic             reset;
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [AW-1:0]    op_reg;
    logic [WIDTH-1:0] op_imm;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] accumulator;
    logic             carry;

    int passCount  = 0;
    int checkCount = 0;

    acc_datapath #(
        .WIDTH(WIDTH),
        .NREGS(NREGS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_reg     (op_reg),
        .op_imm     (op_imm),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .accumulator(accumulator),
        .carry      (carry)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Present one operation away from the clock edge, let one rising edge
    // take it, then settle 1 unit after that edge. If keepValid is set,
    // op_valid stays high afterwards.
    task automatic applyStimulus(input logic [3:0] code, input logic [AW-1:0] rIdx,
                                 input logic [WIDTH-1:0] imm, input bit keepValid = 1'b0);
        op_valid = 1'b1;
        op_code  = code;
        op_reg   = rIdx;
        op_imm   = imm;
        @(posedge clock);
        #1;
        if (!keepValid) op_valid = 1'b0;
    endtask

    // Look at one register through the debug port.
    task automatic checkReg(input string tag, input logic [AW-1:0] idx,
                            input logic [WIDTH-1:0] expected);
        rd_addr = idx;
        #1;
        checkOutput(tag, 16'(rd_data), 16'(expected));
    endtask

    // The whole directed sequence, one step after another.
    initial begin
        reset    = 1'b0;
        op_valid = 1'b0;
        op_code  = OP_LDM;
        op_reg   = '0;
        op_imm   = '0;
        rd_addr  = '0;

        // Reset held low: everything is cleared and ready stays low.
        @(posedge clock);
        @(posedge clock);
        #1;
        checkOutput("rst_ready_low", 16'(op_ready), 16'd0);
        checkOutput("rst_acc", 16'(accumulator), 16'd0);
        checkOutput("rst_carry", 16'(carry), 16'd0);
        checkReg("rst_r0", 4'd0, 4'd0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rel_ready", 16'(op_ready), 16'd1);

        // LDM 9, CLC, ST r3, LDM 8, ADD r3: 8+9 = 17, which gives acc=1
        // and carry=1.
        applyStimulus(OP_LDM, 4'd0, 4'd9);
        checkOutput("ldm9_acc", 16'(accumulator), 16'd9);
        applyStimulus(OP_CLC, 4'd0, 4'd0);
        applyStimulus(OP_ST, 4'd3, 4'd0);
        checkReg("st_r3", 4'd3, 4'd9);
        applyStimulus(OP_LDM, 4'd0, 4'd8);
        applyStimulus(OP_ADD, 4'd3, 4'd0);
        checkOutput("add_acc", 16'(accumulator), 16'd1);
        checkOutput("add_carry", 16'(carry), 16'd1);

        // r1=5, acc=3, carry=1, SUB r1: 3-5 = -2, which gives acc=14 and
        // carry=0 (borrow).
        applyStimulus(OP_LDM, 4'd0, 4'd5);
        applyStimulus(OP_ST, 4'd1, 4'd0);
        applyStimulus(OP_LDM, 4'd0, 4'd3);
        applyStimulus(OP_STC, 4'd0, 4'd0);
        checkOutput("stc_carry", 16'(carry), 16'd1);
        applyStimulus(OP_SUB, 4'd1, 4'd0);
        checkOutput("sub_acc", 16'(accumulator), 16'd14);
        checkOutput("sub_carry", 16'(carry), 16'd0);

        // INC on r4=15 wraps to 0 and leaves carry=1 untouched.
        applyStimulus(OP_LDM, 4'd0, 4'd15);
        applyStimulus(OP_ST, 4'd4, 4'd0);
        applyStimulus(OP_STC, 4'd0, 4'd0);
        applyStimulus(OP_INC, 4'd4, 4'd0);
        checkReg("inc_r4_wrap", 4'd4, 4'd0);
        checkOutput("inc_carry", 16'(carry), 16'd1);

        // CLB, then DAC on 0 gives 15 with carry=0. DAC on 15 gives 14
        // with carry=1.
        applyStimulus(OP_CLB, 4'd0, 4'd0);
        checkOutput("clb_carry", 16'(carry), 16'd0);
        applyStimulus(OP_DAC, 4'd0, 4'd0);
        checkOutput("dac0_acc", 16'(accumulator), 16'd15);
        checkOutput("dac0_carry", 16'(carry), 16'd0);
        applyStimulus(OP_DAC, 4'd0, 4'd0);
        checkOutput("dac15_acc", 16'(accumulator), 16'd14);
        checkOutput("dac15_carry", 16'(carry), 16'd1);

        // IAC: 14 goes to 15 with carry=0, then 15 goes to 0 with carry=1.
        applyStimulus(OP_IAC, 4'd0, 4'd0);
        checkOutput("iac14_acc", 16'(accumulator), 16'd15);
        checkOutput("iac14_carry", 16'(carry), 16'd0);
        applyStimulus(OP_IAC, 4'd0, 4'd0);
        checkOutput("iac15_acc", 16'(accumulator), 16'd0);
        checkOutput("iac15_carry", 16'(carry), 16'd1);

        // Rotates through carry.
        // {0,1001} rotated left gives carry=1, acc=0010.
        // {1,0010} rotated right gives carry=0, acc=1001.
        applyStimulus(OP_LDM, 4'd0, 4'd9);
        applyStimulus(OP_CLC, 4'd0, 4'd0);
        applyStimulus(OP_RAL, 4'd0, 4'd0);
        checkOutput("ral_acc", 16'(accumulator), 16'd2);
        checkOutput("ral_carry", 16'(carry), 16'd1);
        applyStimulus(OP_RAR, 4'd0, 4'd0);
        checkOutput("rar_acc", 16'(accumulator), 16'd9);
        checkOutput("rar_carry", 16'(carry), 16'd0);
        applyStimulus(OP_CMC, 4'd0, 4'd0);
        checkOutput("cmc_carry", 16'(carry), 16'd1);
        applyStimulus(OP_LD, 4'd1, 4'd0);
        checkOutput("ld_r1_acc", 16'(accumulator), 16'd5);

        // XCH r2 with acc=7 and r2=2. op_valid stays high with an LDM 5
        // behind the XCH; that LDM must be ignored during write-back.
        applyStimulus(OP_LDM, 4'd0, 4'd2);
        applyStimulus(OP_ST, 4'd2, 4'd0);
        applyStimulus(OP_LDM, 4'd0, 4'd7);
        applyStimulus(OP_XCH, 4'd2, 4'd0, 1'b1);
        op_code = OP_LDM;
        op_imm  = 4'd5;
        checkOutput("xch_ready_low", 16'(op_ready), 16'd0);
        checkOutput("xch_acc", 16'(accumulator), 16'd2);
        checkReg("xch_r2_before_wb", 4'd2, 4'd2);
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        checkOutput("xch_ready_back", 16'(op_ready), 16'd1);
        checkOutput("xch_no_extra_op", 16'(accumulator), 16'd2);
        checkReg("xch_r2_after_wb", 4'd2, 4'd7);

        // XCH r5 accepted, then reset during XCH_WB. The write-back is
        // dropped and every register reads 0.
        applyStimulus(OP_LDM, 4'd0, 4'd11);
        applyStimulus(OP_XCH, 4'd5, 4'd0);
        checkOutput("xch2_ready_low", 16'(op_ready), 16'd0);
        reset = 1'b0;
        #1;
        checkOutput("xrst_acc", 16'(accumulator), 16'd0);
        checkOutput("xrst_ready", 16'(op_ready), 16'd0);
        checkReg("xrst_r2", 4'd2, 4'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("xrst_rel_ready", 16'(op_ready), 16'd1);
        checkReg("xrst_r5_aborted", 4'd5, 4'd0);
        checkReg("xrst_r3", 4'd3, 4'd0);

        // Decimal adjust on acc=12, carry=0. With DAA built: 12+6 = 18,
        // which gives acc=2 and carry=1. Without it the code is a NOP.
        applyStimulus(OP_LDM, 4'd0, 4'd12);
        applyStimulus(OP_CLC, 4'd0, 4'd0);
        applyStimulus(OP_DAA, 4'd0, 4'd0);
`ifdef ACC_DATAPATH_DAA_EN
        checkOutput("daa_acc", 16'(accumulator), 16'd2);
        checkOutput("daa_carry", 16'(carry), 16'd1);
`else
        checkOutput("daa_nop_acc", 16'(accumulator), 16'd12);
        checkOutput("daa_nop_carry", 16'(carry), 16'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
